vp_validator: RTL and testbench
===============================

Name: vp_validator

Overview:
- Feedback-side counterpart of the value-predictor wrapper.
- Captures each qualified prediction the wrapper emits (pc, result, conf) in an in-order prediction queue.
- Matches queued predictions, in program order, against executed results arriving from the pipeline, and drives the wrapper's feedback interface (fb_pc, fb_actual, fb_mispredict, fb_conf, fb_valid).
- Sits between the predictor wrapper outputs, the execute/writeback stage and the wrapper's feedback inputs.

Parameters:
- P_NUM_PRED, 2, lanes per cycle on every interface; lane 0 is oldest.
- P_DEPTH, 16, prediction queue entries; power of two, >= 2*P_NUM_PRED.
- P_CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- clk_i  in  1  main clock.
- rst_ni  in  1  synchronous reset, active low.
- pred_pc_i  in  P_NUM_PRED x [31:1]  predicted instruction address.
- pred_result_i  in  P_NUM_PRED x [31:1]  predicted value.
- pred_conf_i  in  P_NUM_PRED  confidence saturated flag.
- pred_valid_i  in  P_NUM_PRED  per-lane prediction qualifier.
- ex_pc_i  in  P_NUM_PRED x [31:1]  executed instruction address, program order.
- ex_result_i  in  P_NUM_PRED x [31:1]  true result.
- ex_valid_i  in  P_NUM_PRED  per-lane execute qualifier.
- flush_i  in  1  pipeline flush; discards all outstanding predictions.
- fb_pc_o  out  P_NUM_PRED x [31:1]  feedback address.
- fb_actual_o  out  P_NUM_PRED x [31:1]  feedback true result.
- fb_mispredict_o  out  P_NUM_PRED  predicted value differed, or no matching prediction.
- fb_conf_o  out  P_NUM_PRED  confidence flag of the matched prediction.
- fb_valid_o  out  P_NUM_PRED  feedback qualifier.
- q_count_o  out  $clog2(P_DEPTH)+1  current occupancy.
- drop_cnt_o  out  P_CNT_WIDTH  predictions dropped because the queue was full.
- desync_cnt_o  out  P_CNT_WIDTH  execute results with no matching queue head.

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - head, tail and count go to 0.
  - All fb_* outputs go to 0, and q_count_o, drop_cnt_o and desync_cnt_o go to 0.
  - Reset mid-operation discards queue contents; the next cycle behaves as an empty queue.
- Enqueue:
  - Valid pred lanes are written in lane order (holes compacted) at tail; tail advances modulo P_DEPTH.
  - Free space is the pre-cycle value P_DEPTH - count. Entries dequeued in the same cycle do NOT create space.
  - Lanes beyond free space are dropped, youngest first; drop_cnt_o increments by the number dropped.
- Dequeue / match:
  - Valid ex lanes are processed in lane order against successive heads of the pre-cycle queue contents.
  - There is no bypass: an entry enqueued this cycle cannot be matched this cycle.
- For each valid ex lane k, taking the next candidate head entry E:
  - Queue non-empty and E.pc == ex_pc_i[k]: pop E. Then fb_pc = ex_pc, fb_actual = ex_result, fb_mispredict = (E.result != ex_result), fb_conf = E.conf.
  - Queue empty or pc mismatch: no pop. Then fb_pc = ex_pc, fb_actual = ex_result, fb_mispredict = 1, fb_conf = 0. desync_cnt_o increments.
  - In both cases fb_valid_o[k] = 1.
  - Invalid ex lanes give fb_valid_o[k] = 0, and the other fb fields of that lane hold 0.
  - Feedback lane k corresponds to ex lane k; holes are not compacted on the output.
- Latency: fb_* are registered, so feedback appears 1 cycle after ex_valid_i.
- Count update: count_next = count + enq - deq. Must never exceed P_DEPTH or go below 0; both are assertion properties.
- Pointer wrap: head and tail are $clog2(P_DEPTH) bits and wrap naturally. Full and empty are decided by count, not pointer equality.
- Flush:
  - In the flush_i=1 cycle, matching and feedback still use pre-flush contents (feedback is emitted).
  - After the edge, count, head and tail go to 0, and that cycle's enqueues are discarded without incrementing drop_cnt_o.
- Statistics counters saturate at all-ones and never wrap.

Decomposition:
- Package vp_validator_pkg:
  - typedef vp_entry_t {pc[31:1], result[31:1], conf}.
  - localparams for pointer width and count width.
- One sub-module, vp_pred_queue:
  - Multi-port circular buffer with P_NUM_PRED write and P_NUM_PRED read ports, plus the count, pointer and flush logic.
  - vp_validator holds the match/compare logic, feedback registers and counters.

Test Plan:
- Reset with queue holding 5 entries: rst_ni=0 for 1 cycle -> q_count_o=0, fb_valid_o=0, drop_cnt_o=0; a following ex on lane 0 gets mispredict=1, conf=0.
- Enqueue pc=0x100 result=0x55 conf=1, then ex pc=0x100 result=0x55 -> one cycle later fb_valid=1, fb_mispredict=0, fb_conf=1, fb_actual=0x55.
- Dual lane: enqueue {0x200→0x11, 0x204→0x22}, then ex {0x200→0x11, 0x204→0x23} -> lane0 mispredict=0, lane1 mispredict=1; q_count_o returns to 0.
- Fill to 16, then enqueue 2 more while dequeuing 2 -> both new predictions dropped, drop_cnt_o=2, q_count_o=14.
- Head pc 0x300, ex pc 0x304 -> fb mispredict=1, conf=0, desync_cnt_o=1, q_count_o unchanged; then flush_i=1 -> q_count_o=0.
- Wrap-around: 40 enqueue/dequeue pairs with results i*3 -> every feedback mispredict=0 with the correct fb_actual, and no count errors.

Source files
------------

// File: rtl/vp_validator_pkg.sv
// Shared types and sizing constants for the value-predictor validator.
// A queue entry holds one outstanding prediction awaiting its execute result.
package vp_validator_pkg;

    typedef struct packed {
        logic [31:1] pc;
        logic [31:1] result;
        logic        conf;
    } vp_entry_t;

    localparam int unsigned VP_NUM_PRED = 2;
    localparam int unsigned VP_DEPTH    = 16;
    localparam int unsigned VP_PTR_W    = $clog2(VP_DEPTH);
    localparam int unsigned VP_CNT_W    = VP_PTR_W + 1;

endpackage

// File: rtl/vp_pred_queue.sv
// In-order prediction queue: P_NUM_PRED compacting write ports, P_NUM_PRED read
// ports exposing the oldest entries, occupancy-based full/empty and flush.
module vp_pred_queue
    import vp_validator_pkg::*;
#(
    parameter int unsigned  P_NUM_PRED = VP_NUM_PRED,
    parameter int unsigned  P_DEPTH    = VP_DEPTH,
    localparam int unsigned PTR_W      = $clog2(P_DEPTH),
    localparam int unsigned CNT_W      = PTR_W + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  vp_entry_t [P_NUM_PRED-1:0]  wr_entry_i,
    input  logic [P_NUM_PRED-1:0]       wr_valid_i,
    input  logic [CNT_W-1:0]            pop_num_i,
    output vp_entry_t [P_NUM_PRED-1:0]  rd_entry_o,
    output logic [CNT_W-1:0]            count_o,
    output logic [CNT_W-1:0]            drop_num_o
);

    vp_entry_t              mem_q [P_DEPTH];
    logic [PTR_W-1:0]       head_q;
    logic [PTR_W-1:0]       tail_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       free_slots;
    logic [CNT_W-1:0]       enq_num;
    logic [CNT_W-1:0]       drop_num;
    logic [P_NUM_PRED-1:0]  wr_en;
    logic [PTR_W-1:0]       wr_addr [P_NUM_PRED];

    // Space is judged on the pre-cycle occupancy; same-cycle pops never make room.
    always_comb begin
        free_slots = CNT_W'(P_DEPTH) - count_q;
        enq_num    = '0;
        drop_num   = '0;
        wr_en      = '0;
        // NOTE: blocking accumulation in always_comb lets each lane see the slots claimed by older lanes.
        for (int i = 0; i < P_NUM_PRED; i++) begin
            wr_addr[i] = tail_q + PTR_W'(enq_num);
            if (wr_valid_i[i]) begin
                if (enq_num < free_slots) begin
                    wr_en[i] = 1'b1;
                    enq_num  = enq_num + CNT_W'(1);
                end else begin
                    drop_num = drop_num + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < P_NUM_PRED; i++) begin
            rd_entry_o[i] = mem_q[head_q + PTR_W'(i)];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(pop_num_i);
            tail_q  <= tail_q + PTR_W'(enq_num);
            count_q <= count_q + enq_num - pop_num_i;
        end
    end

    // NOTE: the storage array has no reset; count_q alone decides which slots are live.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i) begin
            for (int i = 0; i < P_NUM_PRED; i++) begin
                if (wr_en[i]) begin
                    mem_q[wr_addr[i]] <= wr_entry_i[i];
                end
            end
        end
    end

    assign count_o    = count_q;
    assign drop_num_o = flush_i ? '0 : drop_num;

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CNT_W'(P_DEPTH));
    a_pop_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop_num_i <= count_q);

endmodule

// File: rtl/vp_validator.sv
// Matches executed results against queued predictions in program order and
// drives registered feedback plus saturating drop/desync statistics.
module vp_validator
    import vp_validator_pkg::*;
#(
    parameter int unsigned  P_NUM_PRED  = VP_NUM_PRED,
    parameter int unsigned  P_DEPTH     = VP_DEPTH,
    parameter int unsigned  P_CNT_WIDTH = 16,
    localparam int unsigned CNT_W       = $clog2(P_DEPTH) + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [P_NUM_PRED-1:0][31:1]  pred_pc_i,
    input  logic [P_NUM_PRED-1:0][31:1]  pred_result_i,
    input  logic [P_NUM_PRED-1:0]        pred_conf_i,
    input  logic [P_NUM_PRED-1:0]        pred_valid_i,
    input  logic [P_NUM_PRED-1:0][31:1]  ex_pc_i,
    input  logic [P_NUM_PRED-1:0][31:1]  ex_result_i,
    input  logic [P_NUM_PRED-1:0]        ex_valid_i,
    input  logic                         flush_i,
    output logic [P_NUM_PRED-1:0][31:1]  fb_pc_o,
    output logic [P_NUM_PRED-1:0][31:1]  fb_actual_o,
    output logic [P_NUM_PRED-1:0]        fb_mispredict_o,
    output logic [P_NUM_PRED-1:0]        fb_conf_o,
    output logic [P_NUM_PRED-1:0]        fb_valid_o,
    output logic [CNT_W-1:0]             q_count_o,
    output logic [P_CNT_WIDTH-1:0]       drop_cnt_o,
    output logic [P_CNT_WIDTH-1:0]       desync_cnt_o
);

    localparam int unsigned SUM_W = P_CNT_WIDTH + 1;

    vp_entry_t [P_NUM_PRED-1:0]   wr_entry;
    vp_entry_t [P_NUM_PRED-1:0]   rd_entry;
    vp_entry_t                    cand;
    logic [CNT_W-1:0]             count;
    logic [CNT_W-1:0]             pop_num;
    logic [CNT_W-1:0]             drop_num;
    logic [CNT_W-1:0]             desync_num;
    logic [P_NUM_PRED-1:0][31:1]  fb_pc_d;
    logic [P_NUM_PRED-1:0][31:1]  fb_actual_d;
    logic [P_NUM_PRED-1:0]        fb_mis_d;
    logic [P_NUM_PRED-1:0]        fb_conf_d;
    logic [P_NUM_PRED-1:0]        fb_valid_d;

    function automatic logic [P_CNT_WIDTH-1:0] sat_add(input logic [P_CNT_WIDTH-1:0] a,
                                                       input logic [CNT_W-1:0] b);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, a} + SUM_W'(b);
        return sum[SUM_W-1] ? '1 : sum[P_CNT_WIDTH-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < P_NUM_PRED; i++) begin
            wr_entry[i] = '{pc: pred_pc_i[i], result: pred_result_i[i], conf: pred_conf_i[i]};
        end
    end

    vp_pred_queue #(
        .P_NUM_PRED (P_NUM_PRED),
        .P_DEPTH    (P_DEPTH)
    ) u_queue (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .wr_entry_i (wr_entry),
        .wr_valid_i (pred_valid_i),
        .pop_num_i  (pop_num),
        .rd_entry_o (rd_entry),
        .count_o    (count),
        .drop_num_o (drop_num)
    );

    // Each valid ex lane tests the next unconsumed head; only a pc hit advances it.
    always_comb begin
        pop_num     = '0;
        desync_num  = '0;
        cand        = '0;
        fb_pc_d     = '0;
        fb_actual_d = '0;
        fb_mis_d    = '0;
        fb_conf_d   = '0;
        fb_valid_d  = '0;
        for (int k = 0; k < P_NUM_PRED; k++) begin
            cand = '0;
            for (int j = 0; j < P_NUM_PRED; j++) begin
                if (CNT_W'(j) == pop_num) begin
                    cand = rd_entry[j];
                end
            end
            if (ex_valid_i[k]) begin
                fb_valid_d[k]  = 1'b1;
                fb_pc_d[k]     = ex_pc_i[k];
                fb_actual_d[k] = ex_result_i[k];
                if (pop_num < count && cand.pc == ex_pc_i[k]) begin
                    fb_mis_d[k]  = (cand.result != ex_result_i[k]);
                    fb_conf_d[k] = cand.conf;
                    pop_num      = pop_num + CNT_W'(1);
                end else begin
                    fb_mis_d[k] = 1'b1;
                    desync_num  = desync_num + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fb_pc_o         <= '0;
            fb_actual_o     <= '0;
            fb_mispredict_o <= '0;
            fb_conf_o       <= '0;
            fb_valid_o      <= '0;
            drop_cnt_o      <= '0;
            desync_cnt_o    <= '0;
        end else begin
            fb_pc_o         <= fb_pc_d;
            fb_actual_o     <= fb_actual_d;
            fb_mispredict_o <= fb_mis_d;
            fb_conf_o       <= fb_conf_d;
            fb_valid_o      <= fb_valid_d;
            drop_cnt_o      <= sat_add(drop_cnt_o, drop_num);
            desync_cnt_o    <= sat_add(desync_cnt_o, desync_num);
        end
    end

    assign q_count_o = count;

endmodule

// File: tb/tb_vp_validator.sv
// Directed bench for vp_validator: reset, matching, lane holes, full/drop,
// desync, flush and pointer wrap, each scenario checked against hand values.
module tb_vp_validator;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [1:0][31:1]  pred_pc, pred_result, ex_pc, ex_result;
    logic [1:0]        pred_conf, pred_valid, ex_valid;
    logic              flush;
    logic [1:0][31:1]  fb_pc, fb_actual;
    logic [1:0]        fb_mispredict, fb_conf, fb_valid;
    logic [4:0]        q_count;
    logic [15:0]       drop_cnt, desync_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_drop     = 0;
    int exp_desync   = 0;
    logic [31:1] exp_pc_q [$];
    logic [31:1] exp_res_q [$];

    vp_validator dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .pred_pc_i       (pred_pc),
        .pred_result_i   (pred_result),
        .pred_conf_i     (pred_conf),
        .pred_valid_i    (pred_valid),
        .ex_pc_i         (ex_pc),
        .ex_result_i     (ex_result),
        .ex_valid_i      (ex_valid),
        .flush_i         (flush),
        .fb_pc_o         (fb_pc),
        .fb_actual_o     (fb_actual),
        .fb_mispredict_o (fb_mispredict),
        .fb_conf_o       (fb_conf),
        .fb_valid_o      (fb_valid),
        .q_count_o       (q_count),
        .drop_cnt_o      (drop_cnt),
        .desync_cnt_o    (desync_cnt)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:1] w(input int v);
        return 31'(v);
    endfunction

    task automatic idle();
        pred_pc = '0; pred_result = '0; pred_conf = '0; pred_valid = '0;
        ex_pc = '0; ex_result = '0; ex_valid = '0; flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_pred(input int lane, input logic [31:1] pc, input logic [31:1] res, input logic conf);
        pred_valid[lane] = 1'b1; pred_pc[lane] = pc; pred_result[lane] = res; pred_conf[lane] = conf;
    endtask

    task automatic set_ex(input int lane, input logic [31:1] pc, input logic [31:1] res);
        ex_valid[lane] = 1'b1; ex_pc[lane] = pc; ex_result[lane] = res;
    endtask

    task automatic test_reset();
        idle(); set_pred(0, w('h10), w(1), 1'b0); set_pred(1, w('h14), w(2), 1'b0); step();
        idle(); set_pred(0, w('h18), w(3), 1'b0); set_pred(1, w('h1c), w(4), 1'b0); step();
        idle(); set_pred(0, w('h20), w(5), 1'b0); set_ex(1, w('hdead), w(0)); step();
        exp_desync = 1;
        tests_run++;
        if (q_count !== 5'd5 || fb_valid !== 2'b10 || fb_mispredict !== 2'b10 || desync_cnt !== 16'(exp_desync)) begin
            tests_failed++;
            $display("FAIL pre_reset: q_count=%0d valid=%b mis=%b desync=%0d, expected 5 10 10 %0d",
                     q_count, fb_valid, fb_mispredict, desync_cnt, exp_desync);
        end
        idle(); rst_ni = 1'b0;
        set_pred(0, w('h24), w(6), 1'b1); set_ex(0, w('h10), w(1));
        step();
        rst_ni = 1'b1; exp_desync = 0;
        tests_run++;
        if (q_count !== 5'd0 || fb_valid !== 2'b00 || fb_mispredict !== 2'b00 || drop_cnt !== 16'd0 || desync_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_state: q_count=%0d valid=%b mis=%b drop=%0d desync=%0d, expected all 0",
                     q_count, fb_valid, fb_mispredict, drop_cnt, desync_cnt);
        end
        idle(); set_ex(0, w('h10), w(1)); step();
        exp_desync = 1;
        tests_run++;
        if (fb_valid !== 2'b01 || fb_mispredict[0] !== 1'b1 || fb_conf[0] !== 1'b0 || q_count !== 5'd0 || desync_cnt !== 16'(exp_desync)) begin
            tests_failed++;
            $display("FAIL post_reset_ex: valid=%b mis=%b conf=%b q_count=%0d desync=%0d, expected 01 1 0 0 %0d",
                     fb_valid, fb_mispredict[0], fb_conf[0], q_count, desync_cnt, exp_desync);
        end
    endtask

    task automatic test_single_match();
        idle(); set_pred(0, w('h100), w('h55), 1'b1); step();
        idle(); set_ex(0, w('h100), w('h55)); step();
        tests_run++;
        if (fb_valid !== 2'b01 || fb_mispredict[0] !== 1'b0 || fb_conf[0] !== 1'b1 ||
            fb_actual[0] !== w('h55) || fb_pc[0] !== w('h100) || q_count !== 5'd0) begin
            tests_failed++;
            $display("FAIL single_match: valid=%b mis=%b conf=%b actual=%h pc=%h q=%0d, expected 01 0 1 55 100 0",
                     fb_valid, fb_mispredict[0], fb_conf[0], fb_actual[0], fb_pc[0], q_count);
        end
    endtask

    task automatic test_no_bypass();
        idle(); set_pred(0, w('h180), w('h18), 1'b1); set_ex(0, w('h180), w('h18)); step();
        exp_desync++;
        tests_run++;
        if (fb_mispredict[0] !== 1'b1 || fb_conf[0] !== 1'b0 || q_count !== 5'd1 || desync_cnt !== 16'(exp_desync)) begin
            tests_failed++;
            $display("FAIL no_bypass: mis=%b conf=%b q=%0d desync=%0d, expected 1 0 1 %0d",
                     fb_mispredict[0], fb_conf[0], q_count, desync_cnt, exp_desync);
        end
        idle(); set_ex(0, w('h180), w('h18)); step();
        tests_run++;
        if (fb_mispredict[0] !== 1'b0 || fb_conf[0] !== 1'b1 || q_count !== 5'd0) begin
            tests_failed++;
            $display("FAIL bypass_followup: mis=%b conf=%b q=%0d, expected 0 1 0", fb_mispredict[0], fb_conf[0], q_count);
        end
    endtask

    task automatic test_dual_lane();
        idle(); set_pred(0, w('h200), w('h11), 1'b0); set_pred(1, w('h204), w('h22), 1'b1); step();
        idle(); set_ex(0, w('h200), w('h11)); set_ex(1, w('h204), w('h23)); step();
        tests_run++;
        if (fb_valid !== 2'b11 || fb_mispredict !== 2'b10 || fb_conf !== 2'b10 ||
            fb_actual[1] !== w('h23) || q_count !== 5'd0) begin
            tests_failed++;
            $display("FAIL dual_lane: valid=%b mis=%b conf=%b actual1=%h q=%0d, expected 11 10 10 23 0",
                     fb_valid, fb_mispredict, fb_conf, fb_actual[1], q_count);
        end
        idle(); set_pred(1, w('h240), w('h44), 1'b1); step();
        idle(); set_ex(1, w('h240), w('h44)); step();
        tests_run++;
        if (fb_valid !== 2'b10 || fb_mispredict !== 2'b00 || fb_conf !== 2'b10 ||
            fb_pc[0] !== w(0) || fb_pc[1] !== w('h240) || q_count !== 5'd0) begin
            tests_failed++;
            $display("FAIL lane_hole: valid=%b mis=%b conf=%b pc0=%h pc1=%h q=%0d, expected 10 00 10 0 240 0",
                     fb_valid, fb_mispredict, fb_conf, fb_pc[0], fb_pc[1], q_count);
        end
    endtask

    task automatic drain(input string name);
        logic [31:1] er [2];
        int n;
        int bad = 0;
        while (exp_pc_q.size() > 0) begin
            idle();
            n = (exp_pc_q.size() >= 2) ? 2 : 1;
            for (int l = 0; l < n; l++) begin
                er[l] = exp_res_q.pop_front();
                set_ex(l, exp_pc_q.pop_front(), er[l]);
            end
            step();
            if (fb_valid !== ((n == 2) ? 2'b11 : 2'b01) || fb_mispredict !== 2'b00 ||
                fb_actual[0] !== er[0] || (n == 2 && fb_actual[1] !== er[1])) bad++;
        end
        idle();
        tests_run++;
        if (bad != 0 || q_count !== 5'd0) begin
            tests_failed++;
            $display("FAIL %s: bad_cycles=%0d q=%0d, expected 0 0", name, bad, q_count);
        end
    endtask

    task automatic test_full_drop();
        logic [31:1] p, r;
        for (int i = 0; i < 8; i++) begin
            idle();
            set_pred(0, w('h1000 + 8 * i), w(2 * i), 1'b0);
            set_pred(1, w('h1004 + 8 * i), w(2 * i + 1), 1'b0);
            exp_pc_q.push_back(w('h1000 + 8 * i)); exp_res_q.push_back(w(2 * i));
            exp_pc_q.push_back(w('h1004 + 8 * i)); exp_res_q.push_back(w(2 * i + 1));
            step();
        end
        idle();
        tests_run++;
        if (q_count !== 5'd16 || drop_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL fill: q=%0d drop=%0d, expected 16 0", q_count, drop_cnt);
        end
        set_pred(0, w('h2000), w('h20), 1'b0); set_pred(1, w('h2004), w('h21), 1'b0);
        for (int l = 0; l < 2; l++) begin
            p = exp_pc_q.pop_front(); r = exp_res_q.pop_front(); set_ex(l, p, r);
        end
        step();
        exp_drop = 2;
        tests_run++;
        if (drop_cnt !== 16'(exp_drop) || q_count !== 5'd14 || fb_valid !== 2'b11 || fb_mispredict !== 2'b00) begin
            tests_failed++;
            $display("FAIL full_drop: drop=%0d q=%0d valid=%b mis=%b, expected 2 14 11 00",
                     drop_cnt, q_count, fb_valid, fb_mispredict);
        end
        idle(); set_pred(0, w('h2008), w('h22), 1'b1); set_pred(1, w('h200c), w('h23), 1'b1);
        exp_pc_q.push_back(w('h2008)); exp_res_q.push_back(w('h22));
        exp_pc_q.push_back(w('h200c)); exp_res_q.push_back(w('h23));
        step();
        idle(); p = exp_pc_q.pop_front(); r = exp_res_q.pop_front(); set_ex(0, p, r); step();
        idle(); set_pred(0, w('h3000), w('h30), 1'b1); set_pred(1, w('h3004), w('h31), 1'b1);
        exp_pc_q.push_back(w('h3000)); exp_res_q.push_back(w('h30));
        step();
        exp_drop = 3;
        tests_run++;
        if (drop_cnt !== 16'(exp_drop) || q_count !== 5'd16) begin
            tests_failed++;
            $display("FAIL partial_drop: drop=%0d q=%0d, expected 3 16", drop_cnt, q_count);
        end
        drain("full_drain");
    endtask

    task automatic test_desync_flush();
        idle(); set_pred(0, w('h300), w(7), 1'b1); step();
        idle(); set_ex(0, w('h304), w(9)); step();
        exp_desync++;
        tests_run++;
        if (fb_valid !== 2'b01 || fb_mispredict[0] !== 1'b1 || fb_conf[0] !== 1'b0 || fb_pc[0] !== w('h304) ||
            fb_actual[0] !== w(9) || q_count !== 5'd1 || desync_cnt !== 16'(exp_desync)) begin
            tests_failed++;
            $display("FAIL desync: valid=%b mis=%b conf=%b pc=%h act=%h q=%0d desync=%0d, expected 01 1 0 304 9 1 %0d",
                     fb_valid, fb_mispredict[0], fb_conf[0], fb_pc[0], fb_actual[0], q_count, desync_cnt, exp_desync);
        end
        idle(); flush = 1'b1; set_ex(0, w('h300), w(7)); set_pred(0, w('h400), w('h40), 1'b1); step();
        tests_run++;
        if (fb_valid !== 2'b01 || fb_mispredict[0] !== 1'b0 || fb_conf[0] !== 1'b1 || q_count !== 5'd0) begin
            tests_failed++;
            $display("FAIL flush_feedback: valid=%b mis=%b conf=%b q=%0d, expected 01 0 1 0",
                     fb_valid, fb_mispredict[0], fb_conf[0], q_count);
        end
        idle(); set_ex(0, w('h400), w('h40)); step();
        exp_desync++;
        tests_run++;
        if (fb_mispredict[0] !== 1'b1 || fb_conf[0] !== 1'b0 || desync_cnt !== 16'(exp_desync)) begin
            tests_failed++;
            $display("FAIL flush_discard: mis=%b conf=%b desync=%0d, expected 1 0 %0d",
                     fb_mispredict[0], fb_conf[0], desync_cnt, exp_desync);
        end
    endtask

    task automatic test_flush_full();
        for (int i = 0; i < 8; i++) begin
            idle(); set_pred(0, w('h600 + 8 * i), w(i), 1'b0); set_pred(1, w('h604 + 8 * i), w(i), 1'b0); step();
        end
        idle(); flush = 1'b1; set_pred(0, w('h700), w(1), 1'b0); set_pred(1, w('h704), w(2), 1'b0); step();
        idle();
        tests_run++;
        if (q_count !== 5'd0 || drop_cnt !== 16'(exp_drop)) begin
            tests_failed++;
            $display("FAIL flush_full: q=%0d drop=%0d, expected 0 %0d", q_count, drop_cnt, exp_drop);
        end
    endtask

    task automatic test_wraparound();
        for (int i = 0; i <= 40; i++) begin
            idle();
            if (i < 40) set_pred(0, w('h5000 + 4 * i), w(3 * i), 1'(i & 1));
            if (i > 0)  set_ex(0, w('h5000 + 4 * (i - 1)), w(3 * (i - 1)));
            step();
            if (i > 0) begin
                tests_run++;
                if (fb_valid !== 2'b01 || fb_mispredict[0] !== 1'b0 || fb_actual[0] !== w(3 * (i - 1)) ||
                    fb_conf[0] !== 1'((i - 1) & 1) || q_count !== ((i < 40) ? 5'd1 : 5'd0)) begin
                    tests_failed++;
                    $display("FAIL wrap[%0d]: valid=%b mis=%b act=%h conf=%b q=%0d, expected 01 0 %h %0d %0d",
                             i - 1, fb_valid, fb_mispredict[0], fb_actual[0], fb_conf[0], q_count,
                             w(3 * (i - 1)), (i - 1) & 1, (i < 40) ? 1 : 0);
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rst_ni = 1'b0;
        step(); step();
        rst_ni = 1'b1;
        test_reset();
        test_single_match();
        test_no_bypass();
        test_dual_lane();
        test_full_drop();
        test_desync_flush();
        test_flush_full();
        test_wraparound();
        tests_run++;
        if (drop_cnt !== 16'(exp_drop) || desync_cnt !== 16'(exp_desync)) begin
            tests_failed++;
            $display("FAIL final_counters: drop=%0d desync=%0d, expected %0d %0d",
                     drop_cnt, desync_cnt, exp_drop, exp_desync);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
